// File: rtl/regfile_pkg.sv
// Shared types, limits and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_INIT,
        RF_RUN
    } rf_state_t;

    localparam int unsigned RF_MAX_RD = 4;

    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every entry once, then holds the file in RUN.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              Ready
);

    localparam int unsigned       DEPTH = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter holds at LAST on exit so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            RF_INIT: begin
                clr_en = !Rst;
                if (cnt_q == LAST) begin
                    state_d = RF_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d = RF_INIT;
            end
        endcase
    end

    assign clr_addr = cnt_q;
    assign Ready    = (state_q == RF_RUN);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with registered reads and a post-reset clear.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        RegWrAddr,
    input  logic [DATA_W-1:0]        RegWrData,
    output logic                     Ready,
    output logic                     WrDropped
);

    localparam int unsigned DEPTH   = rf_depth(ADDR_W);
    localparam bit          ZERO_EN = (ZERO_REG != 0);
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit          BYPASS  = 1'b1;
`else
    localparam bit          BYPASS  = 1'b0;
`endif

    if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..%0d", RF_MAX_RD);
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              wr_zero;
    logic              wr_en;
    logic              wr_drop_q;

    regfile_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .Clk      (Clk),
        .Rst      (Rst),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .Ready    (run)
    );

    assign Ready   = run;
    assign wr_zero = ZERO_EN && (RegWrAddr == '0);
    assign wr_en   = RegWrite && run && !Rst && !wr_zero;

    // Storage has no reset; the clear sequence zeroes it instead.
    always_ff @(posedge Clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[RegWrAddr] <= RegWrData;
        end
    end

    // Reset wins over drop reporting, so a write held during Rst is discarded silently.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= RegWrite && !run;
        end
    end

    assign WrDropped = wr_drop_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_d;
        logic [DATA_W-1:0] data_q;

        assign addr = RdAddr[p*ADDR_W +: ADDR_W];

        always_comb begin
            data_d = mem[addr];
            if (BYPASS && wr_en && (RegWrAddr == addr)) begin
                data_d = RegWrData;
            end
            if (ZERO_EN && (addr == '0)) begin
                data_d = '0;
            end
            if (!run) begin
                data_d = '0;
            end
        end

        always_ff @(posedge Clk) begin
            if (Rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign RdData[p*DATA_W +: DATA_W] = data_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default 32x32/2-port build plus a 16x64/4-port instance.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         rst_a = 1'b1;
    logic [9:0]   rd_addr_a = '0;
    logic [63:0]  rd_data_a;
    logic         we_a = 1'b0;
    logic [4:0]   wa_a = '0;
    logic [31:0]  wd_a = '0;
    logic         ready_a;
    logic         drop_a;

    logic         rst_b = 1'b1;
    logic [15:0]  rd_addr_b = '0;
    logic [255:0] rd_data_b;
    logic         we_b = 1'b0;
    logic [3:0]   wa_b = '0;
    logic [63:0]  wd_b = '0;
    logic         ready_b;
    logic         drop_b;

    regfile_mp u_dut_a (
        .Clk       (Clk),
        .Rst       (rst_a),
        .RdAddr    (rd_addr_a),
        .RdData    (rd_data_a),
        .RegWrite  (we_a),
        .RegWrAddr (wa_a),
        .RegWrData (wd_a),
        .Ready     (ready_a),
        .WrDropped (drop_a)
    );

    regfile_mp #(
        .DATA_W (64),
        .ADDR_W (4),
        .NUM_RD (4)
    ) u_dut_b (
        .Clk       (Clk),
        .Rst       (rst_b),
        .RdAddr    (rd_addr_b),
        .RdData    (rd_data_b),
        .RegWrite  (we_b),
        .RegWrAddr (wa_b),
        .RegWrData (wd_b),
        .Ready     (ready_b),
        .WrDropped (drop_b)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_a [32];
    logic [63:0] ref_b [16];

    typedef struct {
        int           dut;
        int           id;
        logic [255:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        sb_t e;
        @(posedge Clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.dut == 0) check($sformatf("rd_a#%0d", e.id), {192'b0, rd_data_a}, e.exp);
            else            check($sformatf("rd_b#%0d", e.id), rd_data_b, e.exp);
        end
    endtask

    function automatic logic [31:0] model_rd_a(input logic [4:0] ra, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
        if (BYP && we && (wa == ra)) return wd;
        return ref_a[ra];
    endfunction

    function automatic logic [63:0] model_rd_b(input logic [3:0] ra, input logic we,
                                               input logic [3:0] wa, input logic [63:0] wd);
        if (ra == 4'd0) return 64'h0;
        if (BYP && we && (wa == ra)) return wd;
        return ref_b[ra];
    endfunction

    // Drive one RUN cycle on DUT A and queue the read data expected after the edge.
    task automatic drive_a_exp(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] r0, input logic [4:0] r1,
                               input logic [31:0] e0, input logic [31:0] e1, input int id);
        sb_t e;
        we_a = we;
        wa_a = wa;
        wd_a = wd;
        rd_addr_a = {r1, r0};
        e.dut = 0;
        e.id  = id;
        e.exp = {192'b0, e1, e0};
        sb_q.push_back(e);
        if (we && (wa != 5'd0)) ref_a[wa] = wd;
    endtask

    task automatic drive_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [4:0] r0, input logic [4:0] r1, input int id);
        drive_a_exp(we, wa, wd, r0, r1, model_rd_a(r0, we, wa, wd),
                    model_rd_a(r1, we, wa, wd), id);
    endtask

    task automatic drive_b(input logic we, input logic [3:0] wa, input logic [63:0] wd,
                           input int unsigned base, input int id);
        sb_t e;
        logic [3:0] ra;
        we_b = we;
        wa_b = wa;
        wd_b = wd;
        e.dut = 1;
        e.id  = id;
        e.exp = '0;
        for (int p = 0; p < 4; p++) begin
            ra = 4'(base + p * 3);
            rd_addr_b[p*4 +: 4] = ra;
            e.exp[p*64 +: 64] = model_rd_b(ra, we, wa, wd);
        end
        sb_q.push_back(e);
        if (we && (wa != 4'd0)) ref_b[wa] = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) ref_a[i] = '0;
        for (int i = 0; i < 16; i++) ref_b[i] = '0;

        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,
                     BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[6]  = '{1'b1, 5'd9,  32'h0BADF00D, 5'd9,  5'd5,
                     BYP ? 32'h0BADF00D : 32'h0, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 5'd9,  32'h11112222, 5'd9,  5'd9,
                     BYP ? 32'h11112222 : 32'h0BADF00D, BYP ? 32'h11112222 : 32'h0BADF00D};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd31, 32'h11112222, 32'h0};
        vecs[9]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd30, 5'd31,
                     32'h0, BYP ? 32'hFFFFFFFF : 32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'hFFFFFFFF, 32'hA5A5A5A5};
        vecs[11] = '{1'b1, 5'd0,  32'h0000CAFE, 5'd0,  5'd9,  32'h0, 32'h11112222};

        // Reset held for three edges, then the clear sequence with a dropped write at cycle 10.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset_ready", {255'b0, ready_a}, 256'd0);
            check("reset_rd", {192'b0, rd_data_a}, 256'd0);
            check("reset_drop", {255'b0, drop_a}, 256'd0);
        end
        rst_a = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            we_a = (k == 10);
            wa_a = 5'd3;
            wd_a = 32'h55;
            rd_addr_a = 10'($urandom);
            tick();
            check($sformatf("init_ready@%0d", k), {255'b0, ready_a}, {255'b0, (k == 32)});
            check($sformatf("init_rd@%0d", k), {192'b0, rd_data_a}, 256'd0);
            check($sformatf("init_drop@%0d", k), {255'b0, drop_a}, {255'b0, (k == 10)});
        end
        drive_a(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 100);
        tick();

        for (int i = 0; i < 12; i++) begin
            drive_a_exp(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r0, vecs[i].r1,
                        vecs[i].e0, vecs[i].e1, i);
            tick();
            check($sformatf("vec_ready#%0d", i), {255'b0, ready_a}, {255'b0, 1'b1});
            check($sformatf("vec_drop#%0d", i), {255'b0, drop_a}, 256'd0);
        end

        // Fill 1..31, read back, then reset at a random RUN cycle.
        for (int i = 1; i < 32; i++) begin
            drive_a(1'b1, 5'(i), 32'(i * 32'h11), 5'(i), 5'(i - 1), 200 + i);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            drive_a(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 300 + i);
            tick();
        end
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
            drive_a(1'b0, 5'd0, 32'h0, 5'($urandom), 5'($urandom), 400 + i);
            tick();
        end
        rst_a = 1'b1;
        we_a = 1'b0;
        tick();
        check("midrun_rst_ready", {255'b0, ready_a}, 256'd0);
        check("midrun_rst_rd", {192'b0, rd_data_a}, 256'd0);
        rst_a = 1'b0;
        for (int i = 0; i < 32; i++) ref_a[i] = '0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            check($sformatf("reinit_ready@%0d", k), {255'b0, ready_a}, {255'b0, (k == 32)});
        end
        for (int i = 0; i < 16; i++) begin
            drive_a(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 500 + i);
            tick();
        end

        // Wide 4-port instance: 16-entry clear, then random traffic against the model.
        rst_b = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("b_ready@%0d", k), {255'b0, ready_b}, {255'b0, (k == 16)});
        end
        for (int i = 0; i < 40; i++) begin
            drive_b(1'($urandom), 4'($urandom), {$urandom, $urandom}, $urandom_range(0, 15), i);
            tick();
            check($sformatf("b_drop#%0d", i), {255'b0, drop_b}, 256'd0);
        end
        we_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
